// File: rtl/holy_core_pkg.sv
// Shared types and constants for the HOLY core pipeline.
// Holds the fetch FSM encoding and fetch-address helpers.
package holy_core_pkg;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned INSTR_WORD_BYTES = 4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one imem request at a time
// and buffers a single fetched instruction toward decode, honouring redirects.
module fetch_unit
    import holy_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,

    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,

    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,

    input  logic        redirect_valid,
    input  logic [31:0] redirect_target
);

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         pend_q, pend_d;
    logic [31:0]  pend_target_q, pend_target_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    // Low for the reset cycle so no request is shown while rst_n is asserted.
    logic         run_q;

    logic [31:0]  target_aligned;
    logic         req_fire;

    assign target_aligned = word_align(redirect_target);
    assign req_fire       = imem_req_valid && imem_req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_REQ;
            fetch_pc_q    <= RESET_PC;
            pend_q        <= 1'b0;
            pend_target_q <= 32'h0;
            instr_q       <= 32'h0;
            instr_pc_q    <= 32'h0;
            run_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            pend_q        <= pend_d;
            pend_target_q <= pend_target_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            run_q         <= 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        pend_d        = pend_q;
        pend_target_d = pend_target_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;

        unique case (state_q)
            S_REQ: begin
                // The in-flight address stays put; the redirect is parked until the response.
                if (redirect_valid) begin
                    pend_d        = 1'b1;
                    pend_target_d = target_aligned;
                end
                if (req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                    if (!pend_q && !redirect_valid) begin
                        instr_d    = imem_rsp_data;
                        instr_pc_d = fetch_pc_q;
                        state_d    = S_HOLD;
                    end else if (redirect_valid) begin
                        fetch_pc_d = target_aligned;
                        pend_d     = 1'b0;
                    end else begin
                        fetch_pc_d = pend_target_q;
                        pend_d     = 1'b0;
                    end
                end else if (redirect_valid) begin
                    pend_d        = 1'b1;
                    pend_target_d = target_aligned;
                end
            end
            S_HOLD: begin
                // The held instruction caused the redirect, so its target beats pc + 4.
                if (redirect_valid) begin
                    fetch_pc_d = target_aligned;
                    state_d    = S_REQ;
                end else if (instr_ready) begin
                    fetch_pc_d = fetch_pc_q + 32'(INSTR_WORD_BYTES);
                    state_d    = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_comb begin
        imem_req_valid = run_q && (state_q == S_REQ);
        imem_req_addr  = fetch_pc_q;
        instr_valid    = (state_q == S_HOLD);
        instr          = instr_q;
        instr_pc       = instr_pc_q;
        instr_pc_plus4 = instr_pc_q + 32'(INSTR_WORD_BYTES);
    end

    a_addr_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        imem_req_addr[1:0] == 2'b00);

    a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
        imem_req_valid && !imem_req_ready |=> imem_req_valid && $stable(imem_req_addr));

    a_instr_stable: assert property (@(posedge clk) disable iff (!rst_n)
        instr_valid && !instr_ready |=> $stable(instr) && $stable(instr_pc));

    a_rsp_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> state_q == S_WAIT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a fetch-attempt reference model feeds an
// expected-instruction queue that a separate monitor drains as decode sees instructions.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_pc_plus4  (instr_pc_plus4),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0050_0093 ^ (a * 32'h9E37_79B1);
    endfunction

    // Reference model: a fetch attempt starts at the architectural next PC and is
    // spoiled by any redirect seen before (or with) its response.
    typedef enum logic [1:0] {PhReq, PhWait, PhHold} phase_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    phase_t      ph = PhReq;
    bit          started = 1'b0;
    bit          dirty = 1'b0;
    logic [31:0] model_pc = RESET_PC;
    logic [31:0] attempt_addr = RESET_PC;
    bit          mem_out = 1'b0;
    int unsigned mem_delay = 0;
    logic [31:0] mem_addr = 32'h0;
    int unsigned min_lat = 0;
    int unsigned max_lat = 0;

    initial forever begin : model
        logic        fire;
        logic [31:0] tgt;
        @(posedge clk);
        if (!rst_n) begin
            started      = 1'b0;
            ph           = PhReq;
            model_pc     = RESET_PC;
            attempt_addr = RESET_PC;
            dirty        = 1'b0;
            mem_out      = 1'b0;
            mem_delay    = 0;
        end else begin
            fire = started && (ph == PhReq) && imem_req_ready;
            tgt  = {redirect_target[31:2], 2'b00};
            if (imem_rsp_valid) mem_out = 1'b0;
            else if (mem_out && mem_delay > 0) mem_delay--;
            if (fire) begin
                mem_out   = 1'b1;
                mem_addr  = imem_req_addr;
                mem_delay = $urandom_range(max_lat, min_lat);
            end
            case (ph)
                PhReq: begin
                    if (redirect_valid) begin
                        dirty    = 1'b1;
                        model_pc = tgt;
                    end
                    if (fire) ph = PhWait;
                end
                PhWait: begin
                    if (imem_rsp_valid) begin
                        if (!dirty && !redirect_valid) begin
                            exp_q.push_back('{pc: attempt_addr, data: mem_word(attempt_addr)});
                            ph = PhHold;
                        end else begin
                            if (redirect_valid) model_pc = tgt;
                            attempt_addr = model_pc;
                            dirty        = 1'b0;
                            ph           = PhReq;
                        end
                    end else if (redirect_valid) begin
                        dirty    = 1'b1;
                        model_pc = tgt;
                    end
                end
                default: begin
                    if (redirect_valid || instr_ready) begin
                        model_pc     = redirect_valid ? tgt : attempt_addr + 32'd4;
                        attempt_addr = model_pc;
                        dirty        = 1'b0;
                        ph           = PhReq;
                    end
                end
            endcase
            started = 1'b1;
        end
    end

    initial forever begin : monitor
        exp_t cur;
        bit   shown;
        @(negedge clk);
        if (!rst_n) begin
            shown = 1'b0;
            chk1("rst_req_valid", imem_req_valid, 1'b0);
            chk1("rst_instr_valid", instr_valid, 1'b0);
        end else begin
            chk1("req_valid", imem_req_valid, started && (ph == PhReq));
            if (started && ph == PhReq) chk32("req_addr", imem_req_addr, attempt_addr);
            chk1("instr_valid", instr_valid, ph == PhHold);
            if (ph == PhHold) begin
                if (!shown) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_instr actual=%h required=none", instr);
                    end else begin
                        cur = exp_q.pop_front();
                    end
                    shown = 1'b1;
                end
                chk32("instr", instr, cur.data);
                chk32("instr_pc", instr_pc, cur.pc);
                chk32("instr_pc_plus4", instr_pc_plus4, cur.pc + 32'd4);
            end else begin
                shown = 1'b0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        imem_rsp_valid = rst_n && mem_out && (mem_delay == 0);
        imem_rsp_data  = mem_word(mem_addr);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!imem_req_valid && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual=no_request required=request", name);
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!instr_valid && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual=no_instr required=instr", name);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        bit saw_instr;
        repeat (3) tick();

        // Zero-wait latency after reset release
        rst_n = 1'b1;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) begin
                chk1("lat_req_c1", imem_req_valid, 1'b1);
                chk32("lat_addr_c1", imem_req_addr, 32'h0);
            end else if (c == 3) begin
                chk1("lat_valid_c3", instr_valid, 1'b1);
                chk32("lat_instr_c3", instr, 32'h0050_0093);
                chk32("lat_pc_c3", instr_pc, 32'h0);
                chk32("lat_pc4_c3", instr_pc_plus4, 32'h4);
            end else if (c == 4) begin
                chk1("lat_req_c4", imem_req_valid, 1'b1);
                chk32("lat_addr_c4", imem_req_addr, 32'h4);
            end
        end

        // Decode backpressure
        instr_ready = 1'b0;
        wait_valid("bp_valid");
        chk32("bp_pc", instr_pc, 32'h4);
        repeat (5) begin
            tick();
            chk1("bp_hold_valid", instr_valid, 1'b1);
            chk1("bp_no_req", imem_req_valid, 1'b0);
            chk32("bp_hold_pc", instr_pc, 32'h4);
            chk32("bp_hold_instr", instr, mem_word(32'h4));
        end
        instr_ready = 1'b1;
        imem_req_ready = 1'b0;
        tick();
        instr_ready = 1'b0;
        chk32("bp_next_addr", imem_req_addr, 32'h8);

        // Redirect while the request is stalled
        tick();
        chk32("stall_addr_a", imem_req_addr, 32'h8);
        redirect_valid = 1'b1;
        redirect_target = 32'h100;
        tick();
        redirect_valid = 1'b0;
        chk32("stall_addr_b", imem_req_addr, 32'h8);
        tick();
        chk32("stall_addr_c", imem_req_addr, 32'h8);
        imem_req_ready = 1'b1;
        tick();
        saw_instr = 1'b0;
        for (int n = 0; n < 20 && !imem_req_valid; n++) begin
            if (instr_valid) saw_instr = 1'b1;
            tick();
        end
        chk1("stall_dropped", saw_instr, 1'b0);
        chk32("stall_redirect_addr", imem_req_addr, 32'h100);

        // Redirect in hold wins over pc + 4
        wait_valid("hold_valid");
        chk32("hold_pc", instr_pc, 32'h100);
        redirect_valid = 1'b1;
        redirect_target = 32'h203;
        instr_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        chk1("hold_req", imem_req_valid, 1'b1);
        chk32("hold_redirect_addr", imem_req_addr, 32'h200);

        // Redirect coincident with response, then another in the next request
        tick();
        chk1("coinc_rsp", imem_rsp_valid, 1'b1);
        redirect_valid = 1'b1;
        redirect_target = 32'h300;
        tick();
        chk32("coinc_addr", imem_req_addr, 32'h300);
        redirect_target = 32'h400;
        tick();
        redirect_valid = 1'b0;
        wait_req("latest_req");
        chk32("latest_addr", imem_req_addr, 32'h400);
        wait_valid("latest_valid");
        chk32("latest_pc", instr_pc, 32'h400);

        // PC wrap-around
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFFE;
        instr_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        wait_valid("wrap_valid");
        chk32("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        chk32("wrap_pc4", instr_pc_plus4, 32'h0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk32("wrap_addr", imem_req_addr, 32'h0);

        // Reset while a response is outstanding
        min_lat = 3;
        max_lat = 3;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk1("rst_now_req", imem_req_valid, 1'b0);
        chk1("rst_now_valid", instr_valid, 1'b0);
        chk32("rst_now_instr", instr, 32'h0);
        chk32("rst_now_pc", instr_pc, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        min_lat = 0;
        max_lat = 0;
        wait_req("rst_restart");
        chk32("rst_restart_addr", imem_req_addr, RESET_PC);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            imem_req_ready = ($urandom % 10) < 7;
            instr_ready = ($urandom % 10) < 6;
            redirect_valid = ($urandom % 10) == 0;
            redirect_target = (($urandom % 8) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                     : ($urandom & 32'h3FF);
            max_lat = $urandom_range(3, 0);
            tick();
        end
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        repeat (30) tick();

        chk32("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
